// File: rtl/clk_div_multi_rate.sv
// Multi-rate clock divider: square-wave ClkOut at one of up to four rates.
// Rate switches only at half-period boundaries; adds enable, rise Tick and status.
module clk_div_multi_rate #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int NUM_RATES   = 4,
  parameter int RATE0_HZ    = 1,
  parameter int RATE1_HZ    = 5,
  parameter int RATE2_HZ    = 10,
  parameter int RATE3_HZ    = 100,
  parameter int CNT_W       = 25
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       En,
  input  logic [1:0] Speed,
  output logic       ClkOut,
  output logic       Tick,
  output logic [1:0] RateIdx,
  output logic       Pending
);

  localparam int HALF0 = CLK_FREQ_HZ / (2 * RATE0_HZ);
  localparam int HALF1 = CLK_FREQ_HZ / (2 * RATE1_HZ);
  localparam int HALF2 = CLK_FREQ_HZ / (2 * RATE2_HZ);
  localparam int HALF3 = CLK_FREQ_HZ / (2 * RATE3_HZ);

  localparam longint CNT_LIM = longint'(1) << CNT_W;

  localparam bit BAD0 = (HALF0 < 1) ||
    (longint'(HALF0) - 1 >= CNT_LIM);
  localparam bit BAD1 = (NUM_RATES > 1) && ((HALF1 < 1) ||
    (longint'(HALF1) - 1 >= CNT_LIM));
  localparam bit BAD2 = (NUM_RATES > 2) && ((HALF2 < 1) ||
    (longint'(HALF2) - 1 >= CNT_LIM));
  localparam bit BAD3 = (NUM_RATES > 3) && ((HALF3 < 1) ||
    (longint'(HALF3) - 1 >= CNT_LIM));

  if (NUM_RATES < 1 || NUM_RATES > 4) begin : g_bad_num
    $fatal(1, "clk_div_multi_rate: NUM_RATES must be 1..4");
  end

  if (BAD0 || BAD1 || BAD2 || BAD3) begin : g_bad_half
    $fatal(1, "clk_div_multi_rate: half-period out of range");
  end

  localparam logic [CNT_W-1:0] HM0 = CNT_W'(HALF0 - 1);
  localparam logic [CNT_W-1:0] HM1 = CNT_W'(HALF1 - 1);
  localparam logic [CNT_W-1:0] HM2 = CNT_W'(HALF2 - 1);
  localparam logic [CNT_W-1:0] HM3 = CNT_W'(HALF3 - 1);
  localparam logic [2:0]       NR3 = 3'(NUM_RATES);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half_m1;
  logic             speed_ok;
  logic             term;
  logic [1:0]       rate_nxt;

  always_comb begin
    half_m1 = HM0;
    unique case (RateIdx)
      2'd0: half_m1 = HM0;
      2'd1: half_m1 = HM1;
      2'd2: half_m1 = HM2;
      2'd3: half_m1 = HM3;
    endcase
  end

  assign speed_ok = ({1'b0, Speed} < NR3);
  assign term     = (cnt == half_m1);

  // New rate is adopted only at the same edge the output toggles
  assign rate_nxt = (En && term && speed_ok) ? Speed : RateIdx;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt     <= '0;
      ClkOut  <= 1'b0;
      Tick    <= 1'b0;
      RateIdx <= 2'd0;
      Pending <= 1'b0;
    end else begin
      Tick    <= 1'b0;
      RateIdx <= rate_nxt;
      Pending <= speed_ok && (Speed != rate_nxt);
      if (En) begin
        if (term) begin
          cnt    <= '0;
          ClkOut <= ~ClkOut;
          Tick   <= ~ClkOut;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule
